// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants for the fetch-to-decode queue
package if_id_queue_pkg;
   localparam int DEF_XLEN = 32;
   localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
   // pc + inst + int/exp/misal tags
   function automatic int entry_w(input int xlen);
      return 2 * xlen + 3;
   endfunction
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: entry storage with one write port and an async read port, no reset
module if_id_queue_mem import if_id_queue_pkg::*; #(
   parameter int W = entry_w(DEF_XLEN),
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   // write the incoming entry; contents are never cleared, count decides validity
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch/decode decoupling queue with flush and valid/ready handshake
module if_id_queue import if_id_queue_pkg::*; #(
   parameter int XLEN = DEF_XLEN,
   parameter int DEPTH = 2,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(DEF_NOP_INST),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [XLEN-1:0] if_inst,
   input  logic            if_int_flag,
   input  logic            if_exp_flag,
   input  logic            if_inst_addr_misal,
   output logic            enq_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_inst,
   output logic            id_int_flag,
   output logic            id_exp_flag,
   output logic            id_inst_addr_misal,
   input  logic            id_ready,
   output logic [CW-1:0]   q_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = entry_w(XLEN);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [EW-1:0] head;
   logic enq, deq;
   logic [XLEN-1:0] head_pc, head_inst;
   logic head_int, head_exp, head_misal;

   // handshake depends only on registered occupancy, so full rejects even when draining
   assign enq_ready = count != CW'(DEPTH);
   assign id_valid  = count != '0;
   assign enq = if_valid & enq_ready & ~flush;
   assign deq = id_valid & id_ready & ~flush;
   assign q_count = count;

   if_id_queue_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (enq),
      .waddr (wr_ptr),
      .wdata ({if_pc, if_inst, if_int_flag, if_exp_flag, if_inst_addr_misal}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign {head_pc, head_inst, head_int, head_exp, head_misal} = head;
   // empty queue presents a harmless nop with clear tags
   assign id_pc              = id_valid ? head_pc : '0;
   assign id_inst            = id_valid ? head_inst : NOP_INST;
   assign id_int_flag        = id_valid & head_int;
   assign id_exp_flag        = id_valid & head_exp;
   assign id_inst_addr_misal = id_valid & head_misal;

   // pointer/occupancy update; reset and redirect both discard everything
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + AW'(1);
         if (deq) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(enq) - CW'(deq);
      end
   end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue
module tb_if_id_queue;
   logic clk = 0, rst, flush, if_valid, if_int_flag, if_exp_flag, if_inst_addr_misal, id_ready;
   logic [31:0] if_pc, if_inst, id_pc, id_inst;
   logic enq_ready, id_valid, id_int_flag, id_exp_flag, id_inst_addr_misal;
   logic [1:0] q_count;
   int checks = 0, errors = 0;

   if_id_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .if_int_flag(if_int_flag), .if_exp_flag(if_exp_flag), .if_inst_addr_misal(if_inst_addr_misal),
      .enq_ready(enq_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
      .id_int_flag(id_int_flag), .id_exp_flag(id_exp_flag), .id_inst_addr_misal(id_inst_addr_misal),
      .id_ready(id_ready), .q_count(q_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      if_valid = 1; if_pc = pc; if_inst = inst;
   endtask

   initial begin
      rst = 1; flush = 0; if_valid = 0; if_pc = 0; if_inst = 0;
      if_int_flag = 0; if_exp_flag = 0; if_inst_addr_misal = 0; id_ready = 0;
      step(); step();
      rst = 0;
      chk("rst_valid", 32'(id_valid), 0);
      chk("rst_enq_ready", 32'(enq_ready), 1);
      chk("rst_inst", id_inst, 32'h13);
      chk("rst_pc", id_pc, 0);
      chk("rst_count", 32'(q_count), 0);
      chk("rst_flags", {29'd0, id_int_flag, id_exp_flag, id_inst_addr_misal}, 0);

      push(32'h0, 32'h0010_0093); id_ready = 1;
      step(); if_valid = 0;
      chk("single_valid", 32'(id_valid), 1);
      chk("single_pc", id_pc, 32'h0);
      chk("single_inst", id_inst, 32'h0010_0093);
      chk("single_count1", 32'(q_count), 1);
      step();
      chk("single_count0", 32'(q_count), 0);
      chk("single_nop", id_inst, 32'h13);
      chk("single_empty", 32'(id_valid), 0);
      step();
      chk("ready_empty_count", 32'(q_count), 0);

      id_ready = 0;
      push(32'h00, 32'hA0); step();
      push(32'h04, 32'hA1); step();
      chk("fill_count", 32'(q_count), 2);
      chk("fill_enq_ready", 32'(enq_ready), 0);
      push(32'h08, 32'hA2); step();
      chk("drop_count", 32'(q_count), 2);
      chk("drop_head", id_pc, 32'h00);
      chk("drop_inst", id_inst, 32'hA0);
      id_ready = 1; step();
      chk("full_deq_count", 32'(q_count), 1);
      chk("full_deq_head", id_pc, 32'h04);
      chk("full_deq_ready", 32'(enq_ready), 1);
      step(); if_valid = 0;
      chk("pending_head", id_pc, 32'h08);
      chk("pending_inst", id_inst, 32'hA2);
      chk("pending_count", 32'(q_count), 1);
      step();
      chk("drain_count", 32'(q_count), 0);

      for (int i = 0; i < 16; i++) begin
         push(32'(i * 4), 32'h100 + 32'(i)); step();
         chk("stream_pc", id_pc, 32'(i * 4));
         chk("stream_inst", id_inst, 32'h100 + 32'(i));
         chk("stream_count", 32'(q_count), 1);
      end
      if_valid = 0; step();
      chk("stream_end", 32'(q_count), 0);

      id_ready = 0;
      push(32'h00, 32'hB0); step();
      push(32'h04, 32'hB1); step();
      chk("preflush_count", 32'(q_count), 2);
      push(32'h10, 32'hB2); id_ready = 1; flush = 1; step();
      flush = 0; if_valid = 0; id_ready = 0;
      chk("flush_count", 32'(q_count), 0);
      chk("flush_valid", 32'(id_valid), 0);
      chk("flush_enq_ready", 32'(enq_ready), 1);
      chk("flush_inst", id_inst, 32'h13);
      push(32'h80, 32'hB3); step(); if_valid = 0;
      chk("post_flush_head", id_pc, 32'h80);
      chk("post_flush_inst", id_inst, 32'hB3);
      chk("post_flush_count", 32'(q_count), 1);
      id_ready = 1; step(); id_ready = 0;
      flush = 1; step(); flush = 0;
      chk("flush_empty_count", 32'(q_count), 0);
      chk("flush_empty_ready", 32'(enq_ready), 1);

      push(32'h02, 32'hC0); if_inst_addr_misal = 1; if_exp_flag = 1; step();
      push(32'h04, 32'hC1); if_inst_addr_misal = 0; if_exp_flag = 0; if_int_flag = 1; step();
      if_valid = 0; if_int_flag = 0;
      chk("tag0_pc", id_pc, 32'h02);
      chk("tag0_flags", {29'd0, id_int_flag, id_exp_flag, id_inst_addr_misal}, 32'b011);
      id_ready = 1; step(); id_ready = 0;
      chk("tag1_pc", id_pc, 32'h04);
      chk("tag1_flags", {29'd0, id_int_flag, id_exp_flag, id_inst_addr_misal}, 32'b100);
      push(32'h08, 32'hC2); step(); if_valid = 0;
      chk("prerst_count", 32'(q_count), 2);
      rst = 1; flush = 1; step(); rst = 0; flush = 0;
      chk("midrst_valid", 32'(id_valid), 0);
      chk("midrst_enq_ready", 32'(enq_ready), 1);
      chk("midrst_count", 32'(q_count), 0);
      chk("midrst_pc", id_pc, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
